// File: rtl/crossy_pkg.sv
`default_nettype none
// crossy_pkg: shared button-FSM state encoding and 25 MHz timing defaults for the crossy-road game.
// Rev 1.0
package crossy_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    PRESSED   = 2'd2,
    CHK_REL   = 2'd3
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_25M = 250000;
  localparam int unsigned REPEAT_DELAY_25M    = 6250000;
  localparam int unsigned REPEAT_PERIOD_25M   = 2500000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// sync2: two-flop synchroniser for asynchronous pin inputs, async active-low reset.
// Rev 1.0
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= i_d;
      s2_q <= s1_q;
    end
  end

  assign o_q = s2_q;

endmodule
`default_nettype wire

// File: rtl/move_btn_cond.sv
`default_nettype none
// move_btn_cond: sync + debounce the move button into one-cycle move pulses with a pulse counter.
// Optional auto-repeat while held: define MOVE_BTN_AUTOREPEAT_EN. Rev 1.0
module move_btn_cond
  import crossy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25M,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_25M,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_25M
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  input  logic       i_hold,
  output logic       o_move,
  output logic       o_btn_level,
  output logic [7:0] o_move_cnt
);

  localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s2;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             pulse_req;
  logic             move_q, move_d;
  logic [7:0]       move_cnt_q, move_cnt_d;

  sync2 u_sync2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn),
    .o_q     (btn_s2)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_s2) state_d = CHK_PRESS;
      end
      CHK_PRESS: begin
        if (!btn_s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!btn_s2) state_d = CHK_REL;
      end
      CHK_REL: begin
        if (btn_s2) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef MOVE_BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             rpt_phase_q, rpt_phase_d;
  logic             rpt_fire;

  // Phase 0 waits out the initial delay, phase 1 paces the steady repeat; both held in CHK_REL.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire    = 1'b0;
    if (accept) begin
      rpt_d       = '0;
      rpt_phase_d = 1'b0;
    end else if (state_q == PRESSED) begin
      if ((!rpt_phase_q && rpt_q == DELAY_LAST) || (rpt_phase_q && rpt_q == PERIOD_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_d = rpt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

  // Guard keeps pulses separated even with a one-cycle repeat delay or period.
  assign pulse_req = accept | (rpt_fire & ~move_q);
`else
  assign pulse_req = accept;
`endif

  always_comb begin
    move_d     = pulse_req & ~i_hold;
    move_cnt_d = move_cnt_q;
    if (move_d) move_cnt_d = move_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      move_q     <= 1'b0;
      move_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      move_q     <= move_d;
      move_cnt_q <= move_cnt_d;
    end
  end

  assign o_move      = move_q;
  assign o_btn_level = (state_q == PRESSED) || (state_q == CHK_REL);
  assign o_move_cnt  = move_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_move_btn_cond.sv
`default_nettype none
// tb_move_btn_cond: directed self-checking bench, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Rev 1.0
module tb_move_btn_cond;

`ifdef MOVE_BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       hold;
  logic       move;
  logic       level;
  logic [7:0] move_cnt;

  int         checks;
  int         errors;
  logic [7:0] exp_cnt;

  move_btn_cond #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn       (btn),
    .i_hold      (hold),
    .o_move      (move),
    .o_btn_level (level),
    .o_move_cnt  (move_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One call = one rising edge consumed; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    btn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    hold  = 1'b0;
    repeat (3) tick();
    checks++;
    if (move !== 1'b0) begin errors++; $display("FAIL reset_move: got %b expected 0", move); end
    checks++;
    if (level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", level); end
    checks++;
    if (move_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", move_cnt); end
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
    repeat (2) tick();
  endtask

  task automatic test_clean_press();
    logic exp_m, exp_l;
    btn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_m = (i == 7);
      exp_l = (i >= 7);
      if (exp_m) exp_cnt++;
      checks++;
      if (move !== exp_m) begin errors++; $display("FAIL clean_move t%0d: got %b expected %b", i, move, exp_m); end
      checks++;
      if (level !== exp_l) begin errors++; $display("FAIL clean_level t%0d: got %b expected %b", i, level, exp_l); end
    end
    checks++;
    if (move_cnt !== exp_cnt) begin errors++; $display("FAIL clean_cnt: got %0d expected %0d", move_cnt, exp_cnt); end
    go_idle();
  endtask

  task automatic test_bounce();
    logic exp_m;
    for (int i = 1; i <= 14; i++) begin
      btn = (i <= 3) || (i >= 6);
      tick();
      exp_m = (i == 12);
      if (exp_m) exp_cnt++;
      checks++;
      if (move !== exp_m) begin errors++; $display("FAIL bounce_move t%0d: got %b expected %b", i, move, exp_m); end
      checks++;
      if (level !== (i >= 12)) begin errors++; $display("FAIL bounce_level t%0d: got %b expected %b", i, level, (i >= 12)); end
    end
    checks++;
    if (move_cnt !== exp_cnt) begin errors++; $display("FAIL bounce_cnt: got %0d expected %0d", move_cnt, exp_cnt); end
    go_idle();
  endtask

  task automatic test_release_bounce();
    logic exp_m;
    for (int i = 1; i <= 20; i++) begin
      btn = !(i == 8 || i == 9);
      tick();
      exp_m = (i == 7) || (AR && i == 19);
      if (exp_m) exp_cnt++;
      checks++;
      if (move !== exp_m) begin errors++; $display("FAIL relb_move t%0d: got %b expected %b", i, move, exp_m); end
      checks++;
      if (level !== (i >= 7)) begin errors++; $display("FAIL relb_level t%0d: got %b expected %b", i, level, (i >= 7)); end
    end
    btn = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (level !== (i < 7)) begin errors++; $display("FAIL release_level t%0d: got %b expected %b", i, level, (i < 7)); end
      checks++;
      if (move !== 1'b0) begin errors++; $display("FAIL release_move t%0d: got %b expected 0", i, move); end
    end
    checks++;
    if (move_cnt !== exp_cnt) begin errors++; $display("FAIL relb_cnt: got %0d expected %0d", move_cnt, exp_cnt); end
    go_idle();
  endtask

  task automatic test_hold();
    hold = 1'b1;
    btn  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (move !== 1'b0) begin errors++; $display("FAIL hold_move t%0d: got %b expected 0", i, move); end
    end
    checks++;
    if (level !== 1'b1) begin errors++; $display("FAIL hold_level: got %b expected 1", level); end
    checks++;
    if (move_cnt !== exp_cnt) begin errors++; $display("FAIL hold_cnt: got %0d expected %0d", move_cnt, exp_cnt); end
    go_idle();
    hold = 1'b0;
  endtask

  task automatic test_reset_mid_press();
    btn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) exp_cnt++;
    end
    checks++;
    if (level !== 1'b1) begin errors++; $display("FAIL midrst_pre_level: got %b expected 1", level); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 8'd0;
    checks++;
    if (move !== 1'b0) begin errors++; $display("FAIL midrst_move: got %b expected 0", move); end
    checks++;
    if (level !== 1'b0) begin errors++; $display("FAIL midrst_level: got %b expected 0", level); end
    checks++;
    if (move_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", move_cnt); end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 7) exp_cnt++;
      checks++;
      if (move !== (i == 7)) begin errors++; $display("FAIL midrst_repress t%0d: got %b expected %b", i, move, (i == 7)); end
      checks++;
      if (level !== (i >= 7)) begin errors++; $display("FAIL midrst_relevel t%0d: got %b expected %b", i, level, (i >= 7)); end
    end
    checks++;
    if (move_cnt !== exp_cnt) begin errors++; $display("FAIL midrst_recnt: got %0d expected %0d", move_cnt, exp_cnt); end
    go_idle();
  endtask

  task automatic test_autorepeat();
    logic       exp_m;
    logic       prev_m;
    logic [7:0] start_cnt;
    start_cnt = move_cnt;
    prev_m    = 1'b0;
    for (int i = 1; i <= 52; i++) begin
      btn = (i <= 40);
      tick();
      exp_m = (i == 7) ||
              (AR && (i == 17 || i == 22 || i == 27 || i == 32 || i == 37 || i == 42));
      if (exp_m) exp_cnt++;
      checks++;
      if (move !== exp_m) begin errors++; $display("FAIL rpt_move t%0d: got %b expected %b", i, move, exp_m); end
      if (prev_m && move) begin
        errors++;
        $display("FAIL rpt_adjacent t%0d: got two consecutive pulses expected isolated", i);
      end
      prev_m = move;
    end
    checks++;
    if (move_cnt !== exp_cnt) begin errors++; $display("FAIL rpt_cnt: got %0d expected %0d", move_cnt, exp_cnt); end
    checks++;
    if (move_cnt - start_cnt !== (AR ? 8'd7 : 8'd1)) begin
      errors++;
      $display("FAIL rpt_delta: got %0d expected %0d", move_cnt - start_cnt, (AR ? 7 : 1));
    end
    checks++;
    if (level !== 1'b0) begin errors++; $display("FAIL rpt_level_end: got %b expected 0", level); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 8'd0;
    rst_n   = 1'b0;
    btn     = 1'b0;
    hold    = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_hold();
    test_reset_mid_press();
    test_autorepeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/move_btn_cond.md
# move_btn_cond

Conditions the raw, asynchronous player "move" push-button into a clean single-cycle move pulse for the vertical scroll stages (one pulse = one chicken step = one score increment). It sits directly upstream of the scroll/score logic in the VGA crossy-road game, between the top-level button pin and every `move_btn` consumer. It provides synchronisation, press/release debouncing, a hold-off input used during collision reset, and a move counter.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a press or release (10 ms at 25 MHz); ≥1.
- `REPEAT_DELAY`, 6250000: cycles held before the first auto-repeat pulse (250 ms); ≥1.
- `REPEAT_PERIOD`, 2500000: cycles between subsequent auto-repeat pulses (100 ms); ≥1.
- `i_clk` input 1: pixel clock, rising-edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_btn` input 1: raw button, asynchronous to `i_clk`, may bounce.
- `i_hold` input 1: synchronous; while high, move pulses are suppressed and discarded (not queued).
- `o_move` output 1: registered one-cycle move pulse.
- `o_btn_level` output 1: debounced button level.
- `o_move_cnt` output 8: count of emitted `o_move` pulses, wraps 255→0.

## Operation
- Two-flop synchroniser on `i_btn` produces `s2`. The FSM only ever sees `s2`.
- One shared counter `cnt`, width `$clog2` of the largest parameter + 1.
- States:
  - IDLE: `cnt`=0. `s2`=1 → CHK_PRESS with `cnt`=0.
  - CHK_PRESS: `s2`=0 → IDLE (bounce rejected, no pulse). `s2`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → PRESSED, emit pulse. Otherwise `cnt`++.
  - PRESSED: `s2`=0 → CHK_REL with `cnt`=0.
  - CHK_REL: `s2`=1 → PRESSED, no pulse. `s2`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → IDLE. Otherwise `cnt`++.
- `o_btn_level`=1 exactly in PRESSED and CHK_REL.
- "Emit pulse" means `o_move`←~`i_hold` for one cycle. `o_move_cnt` increments only when `o_move` is actually set.
- A press is one pulse regardless of hold length, unless auto-repeat is compiled in.
- `i_hold` does not affect FSM state. A press accepted under hold is lost, not deferred.

## Timing
- Reset (async assert, sync release): state IDLE, `cnt`=0, sync flops 0, `o_move`=0, `o_btn_level`=0, `o_move_cnt`=0.
- Press latency: with `i_btn` stable high from clock edge k, `o_move` is high for the cycle after edge k+`DEBOUNCE_CYCLES`+2, and low on the next edge.
- `o_btn_level` rises on the same edge as `o_move`.
- Release latency: `o_btn_level` falls `DEBOUNCE_CYCLES`+2 edges after `i_btn` is first sampled low.
- A bounce shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes `o_btn_level`.
- Reset mid-press: the FSM returns to IDLE. A button still held after release of reset is a new press and produces one pulse after the full debounce latency.
- `o_move` is never high on two consecutive cycles.

## Configuration
- `MOVE_BTN_AUTOREPEAT_EN` defined:
  - A second counter `rpt` clears on entry to PRESSED from CHK_PRESS.
  - `rpt` counts in PRESSED and holds its value in CHK_REL; returning to PRESSED from CHK_REL resumes the count without clearing.
  - An extra pulse is emitted when `rpt` reaches `REPEAT_DELAY`-1 and every `REPEAT_PERIOD` cycles thereafter. These pulses are subject to `i_hold` and counted in `o_move_cnt`.
- Not defined: no `rpt` logic is synthesised; exactly one pulse per accepted press.

## Structure
- Shared package `crossy_pkg`: state enum (IDLE, CHK_PRESS, PRESSED, CHK_REL) and the default timing constants at 25 MHz.
- Sub-module `sync2`: two-flop synchroniser with async active-low reset, reused for any other pin inputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
- Clean press: `i_btn` high from edge 10 → `o_move` high only during cycle after edge 16; `o_btn_level`=1; `o_move_cnt`=1.
- Bounce: `i_btn` high for 3 cycles, low for 2, then stable high → exactly one pulse, 6 cycles after the stable-high start; count=1.
- Release bounce: while PRESSED, `i_btn` low for 2 cycles then high → `o_btn_level` stays 1, no pulse. Stable low → `o_btn_level` falls 6 edges later.
- Hold: `i_hold`=1 across an accepted press → `o_move` stays 0, `o_move_cnt` unchanged, `o_btn_level`=1.
- Reset mid-press: assert `i_rst_n`=0 in PRESSED with button held → all outputs 0 immediately. After release, one pulse 6 edges later.
- Auto-repeat (macro defined): hold 40 cycles → pulses at acceptance, +10, +15, +20, +25, +30, +35; `o_move_cnt`=7. Macro undefined → `o_move_cnt`=1.
